// File: rtl/rgb_frame_writer_pkg.sv
// isp_pkg: shared widths and writer state encoding for the ISP write-back path
package isp_pkg;
    localparam int WORD_W   = 64;
    localparam int PIX_BITS = 48;
    localparam int ADR_W    = 32;
    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} wr_state_t;
endpackage

// File: rtl/rgb_frame_writer_if.sv
// rgb_frame_writer_if: valid/ready frame-buffer write port
interface rgb_frame_writer_if;
    import isp_pkg::*;
    logic [ADR_W-1:0]  wr_adr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_v;
    logic              wr_ready;
    modport master (output wr_adr, output wr_data, output wr_v, input wr_ready);
    modport slave  (input wr_adr, input wr_data, input wr_v, output wr_ready);
endinterface

// File: rtl/rgb_frame_writer_word_fifo.sv
// word_fifo: synchronous FIFO whose head sits in an output register; capacity DEPTH counts that register
module word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_v,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, total;
    logic pop, acc, load;
    assign total = cnt + (AW+1)'(out_v);
    assign full  = total == (AW+1)'(DEPTH);
    assign empty = total == '0;
    assign pop   = out_v && out_ready;
    assign acc   = in_v && (!full || pop);
    assign load  = cnt != '0 && (!out_v || pop);
    // storage write on every accepted push
    always_ff @(posedge clk) begin
        if (acc) mem[wp] <= in_data;
    end
    // pointers, occupancy and the head register; a pop while full frees room for a same-cycle push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clr) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            out_v    <= 1'b0;
            out_data <= '0;
        end else begin
            if (acc) wp <= wp + AW'(1);
            cnt <= cnt + (AW+1)'(acc) - (AW+1)'(load);
            if (load) begin
                out_data <= mem[rp];
                rp       <= rp + AW'(1);
                out_v    <= 1'b1;
            end else if (pop) begin
                out_v <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer: packs 48-bit RGB pixels into 64-bit words and writes them to a frame buffer
module rgb_frame_writer
    import isp_pkg::*;
#(
    parameter int PIXEL_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADR_W-1:0]       base_adr,
    input  logic                   data_v,
    input  logic [PIXEL_WIDTH-1:0] red,
    input  logic [PIXEL_WIDTH-1:0] green,
    input  logic [PIXEL_WIDTH-1:0] blue,
    input  logic                   done,
    rgb_frame_writer_if.master     wr,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [31:0]            pix_count
);
    wr_state_t state;
    logic [1:0] phase;
    logic [PIX_BITS-1:0] res, px;
    logic [ADR_W-1:0] adr;
    logic [WORD_W-1:0] pix_word, push_data, fifo_data;
    logic take, push, hs, drop, full, empty, fifo_v;
    assign px   = {red, green, blue};
    assign take = state == RUN && data_v;
    assign hs   = fifo_v && wr.wr_ready;
    // phase 1/2/3 means 48/32/16 residue bits, held right-aligned in res
    assign pix_word  = phase == 2'd1 ? {px[15:0], res} :
                       phase == 2'd2 ? {px[31:0], res[31:0]} : {px, res[15:0]};
    assign push      = !start && phase != 2'd0 && (take || state == FLUSH);
    assign push_data = state == FLUSH ? {16'b0, res} : pix_word;
    assign drop      = push && full && !hs;
    word_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .clr(start),
        .in_v(push), .in_data(push_data),
        .out_v(fifo_v), .out_data(fifo_data), .out_ready(wr.wr_ready),
        .full(full), .empty(empty)
    );
    assign wr.wr_v    = fifo_v;
    assign wr.wr_data = fifo_data;
    assign wr.wr_adr  = adr;
    // frame FSM with packer residue, write address, pixel count and sticky flags; start aborts/restarts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            phase      <= 2'd0;
            res        <= '0;
            adr        <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else if (start) begin
            state      <= RUN;
            phase      <= 2'd0;
            res        <= '0;
            adr        <= base_adr;
            pix_count  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (hs) adr <= adr + ADR_W'(1);
            if (drop) overflow <= 1'b1;
            if (take) begin
                pix_count <= pix_count + 32'd1;
                phase     <= phase + 2'd1;
                res       <= phase == 2'd0 ? px :
                             phase == 2'd1 ? {16'b0, px[47:16]} : {32'b0, px[47:32]};
            end
            case (state)
                RUN:   if (done) state <= FLUSH;
                FLUSH: begin
                    phase <= 2'd0;
                    state <= DRAIN;
                end
                DRAIN: if (empty) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_frame_writer.sv
// tb_rgb_frame_writer: randomized frames checked against a bit-stream packing model
module tb_rgb_frame_writer;
    logic        clk, reset, start, data_v, done;
    logic [31:0] base_adr;
    logic [15:0] red, green, blue;
    logic        frame_done, overflow;
    logic [31:0] pix_count;
    rgb_frame_writer_if bus();

    rgb_frame_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr),
        .data_v(data_v), .red(red), .green(green), .blue(blue), .done(done),
        .wr(bus), .frame_done(frame_done), .overflow(overflow), .pix_count(pix_count)
    );

    int n_checks, n_pass, stall;
    bit rmode;
    logic [15:0] pr [32], pg [32], pb [32];
    logic [31:0] got_adr [$];
    logic [63:0] got_data [$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // record each handshake that will complete at the coming rising edge
    always @(negedge clk) begin
        if (reset && bus.wr_v && bus.wr_ready) begin
            got_adr.push_back(bus.wr_adr);
            got_data.push_back(bus.wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // stream model: pixel p at bits [48p+47:48p], word k is bits [64k+63:64k]
    function automatic logic [63:0] model_word(input int n, input int k);
        logic [2047:0] s = '0;
        for (int p = 0; p < n; p++) s[48*p +: 48] = {pr[p], pg[p], pb[p]};
        return s[64*k +: 64];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        start = 0; data_v = 0; done = 0;
        red = 16'($urandom); green = 16'($urandom); blue = 16'($urandom);
        if (stall > 0) begin
            bus.wr_ready = 0;
            stall--;
        end else begin
            bus.wr_ready = (rmode && bus.wr_ready) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic fill_rand(input int n);
        for (int p = 0; p < n; p++) begin
            pr[p] = 16'($urandom); pg[p] = 16'($urandom); pb[p] = 16'($urandom);
        end
    endtask

    task automatic run_frame(input logic [31:0] base, input int n, input bit coinc, input int gap, input bit lat);
        got_adr.delete(); got_data.delete();
        start = 1; base_adr = base;
        step();
        for (int p = 0; p < n; p++) begin
            while (gap > 0 && int'($urandom_range(0, 99)) < gap) step();
            data_v = 1; red = pr[p]; green = pg[p]; blue = pb[p];
            done = coinc && p == n - 1;
            step();
            if (lat && p == 1) check("lat_n", bus.wr_v, 0);
            if (lat && p == 2) check("lat_n1", bus.wr_v, 1);
        end
        if (!coinc) begin
            done = 1;
            step();
        end
        check("fd_low", frame_done, 0);
        for (int i = 0; i < 300 && !frame_done; i++) step();
        check("frame_done", frame_done, 1);
    endtask

    task automatic verify(input logic [31:0] base, input int n, input int keep, input bit ov);
        check("pix_count", pix_count, n);
        check("overflow", overflow, ov);
        check("nwords", got_data.size(), keep);
        for (int k = 0; k < keep && k < got_data.size(); k++) begin
            check("adr", got_adr[k], base + k);
            check("data", got_data[k], model_word(n, k));
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; stall = 0; rmode = 0;
        reset = 0; start = 0; data_v = 0; done = 0; base_adr = 0;
        red = 0; green = 0; blue = 0; bus.wr_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wv", bus.wr_v, 0);
        check("rst_wdata", bus.wr_data, 0);
        check("rst_wadr", bus.wr_adr, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ov", overflow, 0);
        check("rst_pc", pix_count, 0);
        reset = 1;

        pr[0] = 16'h1; pg[0] = 16'h2; pb[0] = 16'h3;
        pr[1] = 16'h6; pg[1] = 16'h5; pb[1] = 16'h4;
        pr[2] = 16'h9; pg[2] = 16'h8; pb[2] = 16'h7;
        pr[3] = 16'hC; pg[3] = 16'hB; pb[3] = 16'hA;
        run_frame(32'h100, 4, 0, 0, 1);
        verify(32'h100, 4, 3, 0);
        check("basic_w0", got_data.size() > 0 ? got_data[0] : 64'hx, 64'h0004_0001_0002_0003);
        check("basic_w2", got_data.size() > 2 ? got_data[2] : 64'hx, 64'h000C_000B_000A_0009);

        fill_rand(5);
        run_frame(32'h180, 5, 0, 30, 0);
        verify(32'h180, 5, 4, 0);
        check("flush_word", got_data.size() > 3 ? got_data[3] : 64'hx, {16'h0, pr[4], pg[4], pb[4]});

        fill_rand(16);
        stall = 20;
        run_frame(32'h400, 16, 0, 0, 0);
        verify(32'h400, 16, 8, 1);

        fill_rand(16);
        stall = 5;
        run_frame(32'h500, 16, 0, 0, 0);
        verify(32'h500, 16, 12, 0);

        fill_rand(3);
        run_frame(32'h600, 3, 1, 0, 0);
        verify(32'h600, 3, 3, 0);

        rmode = 1;
        for (int f = 0; f < 8; f++) begin
            int n;
            bit c;
            logic [31:0] b;
            n = $urandom_range(1, 16);
            c = 1'($urandom_range(0, 1));
            b = $urandom;
            fill_rand(n);
            run_frame(b, n, c, 30, 0);
            verify(b, n, (48 * n + 63) / 64, 0);
        end
        rmode = 0;

        fill_rand(6);
        stall = 40;
        start = 1; base_adr = 32'h300;
        step();
        check("abort_fd_clr", frame_done, 0);
        for (int p = 0; p < 6; p++) begin
            data_v = 1; red = pr[p]; green = pg[p]; blue = pb[p];
            step();
        end
        check("abort_pre_wv", bus.wr_v, 1);
        check("abort_pre_adr", bus.wr_adr, 32'h300);
        check("abort_fd_low", frame_done, 0);
        stall = 0;
        fill_rand(5);
        run_frame(32'h200, 5, 0, 0, 0);
        verify(32'h200, 5, 4, 0);

        fill_rand(8);
        stall = 60;
        start = 1; base_adr = 32'h700;
        step();
        for (int p = 0; p < 8; p++) begin
            data_v = 1; red = pr[p]; green = pg[p]; blue = pb[p];
            step();
        end
        check("rst_pre_wv", bus.wr_v, 1);
        reset = 0;
        #1;
        check("mrst_wv", bus.wr_v, 0);
        check("mrst_wdata", bus.wr_data, 0);
        check("mrst_wadr", bus.wr_adr, 0);
        check("mrst_pc", pix_count, 0);
        check("mrst_fd", frame_done, 0);
        check("mrst_ov", overflow, 0);
        reset = 1;
        stall = 0;
        got_adr.delete(); got_data.delete();
        for (int i = 0; i < 6; i++) begin
            data_v = 1;
            step();
        end
        check("idle_pc", pix_count, 0);
        check("idle_wv", bus.wr_v, 0);
        check("idle_nwords", got_data.size(), 0);
        fill_rand(7);
        run_frame(32'h800, 7, 0, 0, 0);
        verify(32'h800, 7, 6, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
